// File: rtl/serial_subtractor_nbit_pkg.sv
// Shared types for the bit-serial subtractor: controller state encoding.
package subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_nbit_if.sv
// Start/busy/done request bus of the serial subtractor.
// Optional flag signals exist only when SUBSERIAL_FLAGS_EN is defined.
interface serial_subtractor_nbit_if #(parameter int N = 4);

   logic         start;
   logic [N-1:0] operand_a;
   logic [N-1:0] operand_b;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         borrow_out;
`ifdef SUBSERIAL_FLAGS_EN
   logic         zero;
   logic         negative;
   logic         overflow;

   modport master (
      output start, operand_a, operand_b, borrow_in,
      input  busy, done, result, borrow_out, zero, negative, overflow
   );
   modport slave (
      input  start, operand_a, operand_b, borrow_in,
      output busy, done, result, borrow_out, zero, negative, overflow
   );
`else
   modport master (
      output start, operand_a, operand_b, borrow_in,
      input  busy, done, result, borrow_out
   );
   modport slave (
      input  start, operand_a, operand_b, borrow_in,
      output busy, done, result, borrow_out
   );
`endif

endinterface

// File: rtl/serial_subtractor_nbit_full_subtractor.sv
// One-bit full-subtractor cell: diff = A - B - bin, bout = borrow out.
module full_subtractor (
   input  logic A,
   input  logic B,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = A ^ B ^ bin;
   assign bout = (~A & B) | (~(A ^ B) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell plus borrow flop.
// Status flags zero/negative/overflow are built only with SUBSERIAL_FLAGS_EN.
module serial_subtractor_nbit
   import subtractor_pkg::*;
#(
   parameter int N = 4
) (
   input logic                    clk,
   input logic                    rst,
   serial_subtractor_nbit_if.slave bus
);

   localparam int CW = $clog2(N + 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   a_sh_q, a_sh_d;
   logic [N-1:0]   b_sh_q, b_sh_d;
   logic [N-1:0]   r_sh_q, r_sh_d;
   logic           bor_q, bor_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [N-1:0]   result_q, result_d;
   logic           borrow_out_q, borrow_out_d;
`ifdef SUBSERIAL_FLAGS_EN
   logic           a_msb_q, a_msb_d;
   logic           b_msb_q, b_msb_d;
   logic           zero_q, zero_d;
   logic           negative_q, negative_d;
   logic           overflow_q, overflow_d;
`endif

   logic           cell_diff;
   logic           cell_bout;
   logic [N-1:0]   r_next;

   full_subtractor u_cell (
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .bin  (bor_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // NOTE: every _d starts as its _q so no branch leaves a variable unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      r_sh_d       = r_sh_q;
      bor_d        = bor_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      result_d     = result_q;
      borrow_out_d = borrow_out_q;
`ifdef SUBSERIAL_FLAGS_EN
      a_msb_d      = a_msb_q;
      b_msb_d      = b_msb_q;
      zero_d       = zero_q;
      negative_d   = negative_q;
      overflow_d   = overflow_q;
`endif

      // Shift right written as shift-then-overwrite so N = 1 needs no special case.
      r_next        = r_sh_q >> 1;
      r_next[N-1]   = cell_diff;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SHIFT;
               busy_d  = 1'b1;
               cnt_d   = '0;
               a_sh_d  = bus.operand_a;
               b_sh_d  = bus.operand_b;
               bor_d   = bus.borrow_in;
`ifdef SUBSERIAL_FLAGS_EN
               a_msb_d = bus.operand_a[N-1];
               b_msb_d = bus.operand_b[N-1];
`endif
            end
         end
         SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            r_sh_d = r_next;
            bor_d  = cell_bout;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               state_d      = DONE;
               busy_d       = 1'b0;
               done_d       = 1'b1;
               result_d     = r_next;
               borrow_out_d = cell_bout;
`ifdef SUBSERIAL_FLAGS_EN
               zero_d       = (r_next == '0);
               negative_d   = r_next[N-1];
               overflow_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ r_next[N-1]);
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: datapath registers are reset alongside control so an aborted run leaves no stale bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         r_sh_q       <= '0;
         bor_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= '0;
         borrow_out_q <= 1'b0;
`ifdef SUBSERIAL_FLAGS_EN
         a_msb_q      <= 1'b0;
         b_msb_q      <= 1'b0;
         zero_q       <= 1'b0;
         negative_q   <= 1'b0;
         overflow_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         r_sh_q       <= r_sh_d;
         bor_q        <= bor_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         result_q     <= result_d;
         borrow_out_q <= borrow_out_d;
`ifdef SUBSERIAL_FLAGS_EN
         a_msb_q      <= a_msb_d;
         b_msb_q      <= b_msb_d;
         zero_q       <= zero_d;
         negative_q   <= negative_d;
         overflow_q   <= overflow_d;
`endif
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.result     = result_q;
   assign bus.borrow_out = borrow_out_q;
`ifdef SUBSERIAL_FLAGS_EN
   assign bus.zero       = zero_q;
   assign bus.negative   = negative_q;
   assign bus.overflow   = overflow_q;
`endif

endmodule

// File: doc/serial_subtractor_nbit.md
# serial_subtractor_nbit

Bit-serial N-bit subtractor that computes operand_a − operand_b − borrow_in one bit per clock, LSB first, through a single one-bit full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart of the team's parallel ripple-carry adder. It trades latency for area in the ALU datapath and uses a start/busy/done handshake.

## Interface
- N, default 4: operand and result width in bits; legal range N ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- operand_a  input  N  minuend; captured on an accepted start.
- operand_b  input  N  subtrahend; captured on an accepted start.
- borrow_in  input  1  initial borrow; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result is valid.
- result  output  N  difference; held stable from done until the next accepted start.
- borrow_out  output  1  final borrow; 1 iff unsigned a < b + borrow_in.
- zero, negative, overflow  output  1 each  status flags; present only with SUBSERIAL_FLAGS_EN.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when start = 1.
  - Latch operand_a, operand_b and borrow_in into shift registers.
  - Clear the bit counter.
- SHIFT, once per cycle:
  - Take bit a, bit b and borrow bor from the LSBs and the borrow flip-flop.
  - d = a ^ b ^ bor.
  - bor_next = (~a & b) | (~(a ^ b) & bor).
  - Shift the result register right and insert d at the MSB.
  - Shift both operand registers right.
  - Increment the counter.
- SHIFT → DONE after exactly N SHIFT cycles.
  - Counter width is $clog2(N+1).
  - N = 1 gives one SHIFT cycle.
- DONE → IDLE unconditionally after one cycle.
- start asserted in SHIFT or DONE is ignored; operands are not re-captured and the operation is not restarted.
- Arithmetic is modulo 2^N; result equals (a − b − borrow_in) mod 2^N.
- borrow_out is updated only on the SHIFT→DONE transition and held afterwards.

## Timing
- Reset values (rst high at an edge, regardless of state):
  - state = IDLE.
  - busy = 0, done = 0.
  - result = 0, borrow_out = 0.
  - all flags = 0.
- Reset mid-operation aborts the operation: no done pulse, partial result discarded.
- Latency, for start sampled high at edge k in IDLE:
  - busy = 1 after edges k … k+N−1, i.e. N cycles.
  - done = 1 for exactly one cycle after edge k+N.
  - result, borrow_out and flags are valid in that same cycle.
  - Start-to-done latency is N+1 cycles.
- Throughput: a new start is accepted at the earliest in the cycle after done, which is IDLE. Back-to-back operations therefore start every N+2 cycles.
- result and flags hold their last completed values through IDLE and SHIFT.
- result is not updated visibly mid-operation: the output register loads from the shift register at SHIFT→DONE.

## Configuration
- Macro: SUBSERIAL_FLAGS_EN.
- Defined: zero, negative and overflow ports exist and are registered at SHIFT→DONE.
  - zero = (result == 0).
  - negative = result[N−1].
  - overflow = (a[N−1] ^ b[N−1]) & (a[N−1] ^ result[N−1]), using the captured operands.
- Not defined: the three ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package subtractor_pkg holds the typedef enum for states IDLE/SHIFT/DONE.
- One natural sub-module: full_subtractor.
  - Combinational one-bit cell.
  - Ports A, B, bin → diff, bout.
  - Instantiated once in the serial datapath.

## Test plan
- N=4, a=7, b=3, bin=0, start pulse: busy for 4 cycles, then done pulse; result=4, borrow_out=0, zero=0, overflow=0.
- N=4, a=3, b=7, bin=0: result=0xC, borrow_out=1, negative=1, overflow=0.
- N=4, a=0x8, b=0x1: result=0x7, borrow_out=0, overflow=1; also a=0, b=0, bin=1: result=0xF, borrow_out=1.
- N=4, a=5, b=5: result=0, zero=1, borrow_out=0; result and flags remain held through the following IDLE cycles.
- start re-asserted with new operands during SHIFT: ignored, and the original difference is reported; start in the cycle after done is accepted.
- rst pulsed two cycles into an operation: no done pulse, all outputs 0, IDLE; a following start completes normally. Repeat with N=1 to check the single-SHIFT path.
